hazard_unit: RTL

Central stall/flush and forwarding controller for the five-stage pipeline. It compares decode-stage source registers against destinations in flight in E, M and W. It drives the hold enables of the PC and F/D register and the `CLR` bubble input of the D/E register. It also tracks the multi-cycle multiply/divide unit (MDU) so HI/LO consumers wait until the result is ready.

---
 rtl/hazard_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush and forwarding control for the five-stage pipeline,
// plus an idle/busy tracker for the multi-cycle multiply/divide unit.
// Optional feature: define HAZARD_STALL_CNT_EN to add the 32-bit stall_count output.
module hazard_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [1:0] Tuse_Rs_D,
    input  logic [1:0] Tuse_Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic       RegWrite_E,
    input  logic [1:0] Tnew_E,
    input  logic [4:0] WriteReg_M,
    input  logic       RegWrite_M,
    input  logic [1:0] Tnew_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_W,
    input  logic       MDUStart_E,
    input  logic       MDUIsDiv_E,
    input  logic       MDUUse_D,
    output logic       stall_F,
    output logic       stall_D,
    output logic       CLR,
    output logic       busy,
    output logic [1:0] FwdRs_D,
    output logic [1:0] FwdRt_D,
    output logic [1:0] FwdRs_E,
    output logic [1:0] FwdRt_E
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mdu_state_t;

    mdu_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          stall;
    logic          stall_rs, stall_rt, stall_mdu;

    // Producer X blocks source r when it writes r and its result arrives too late.
    function automatic logic src_stall(
        input logic [4:0] r,
        input logic [1:0] tuse,
        input logic [4:0] wr_e,
        input logic       we_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [1:0] tnew_m
    );
        logic hit_e, hit_m;
        hit_e = we_e && (wr_e == r) && (tuse < tnew_e);
        hit_m = we_m && (wr_m == r) && (tuse < tnew_m);
        return (r != 5'd0) && (hit_e || hit_m);
    endfunction

    // Forward select: M (2) wins over W (1); $0 always reads the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] wr_m,
        input logic       we_m,
        input logic [1:0] tnew_m,
        input logic [4:0] wr_w,
        input logic       we_w
    );
        if (r == 5'd0)                                   return 2'd0;
        else if (we_m && (wr_m == r) && (tnew_m == 2'd0)) return 2'd2;
        else if (we_w && (wr_w == r))                    return 2'd1;
        else                                             return 2'd0;
    endfunction

    // Stall decision and forwarding selects, all zero-latency.
    always_comb begin
        stall_rs  = src_stall(Rs_D, Tuse_Rs_D, WriteReg_E, RegWrite_E, Tnew_E,
                              WriteReg_M, RegWrite_M, Tnew_M);
        stall_rt  = src_stall(Rt_D, Tuse_Rt_D, WriteReg_E, RegWrite_E, Tnew_E,
                              WriteReg_M, RegWrite_M, Tnew_M);
        // Reset masks the MDU term so a start seen during reset cannot stall.
        stall_mdu = reset && MDUUse_D && (busy || MDUStart_E);
        stall     = stall_rs || stall_rt || stall_mdu;
        stall_F   = stall;
        stall_D   = stall;
        CLR       = stall;
        FwdRs_D   = fwd_sel(Rs_D, WriteReg_M, RegWrite_M, Tnew_M, WriteReg_W, RegWrite_W);
        FwdRt_D   = fwd_sel(Rt_D, WriteReg_M, RegWrite_M, Tnew_M, WriteReg_W, RegWrite_W);
        FwdRs_E   = fwd_sel(Rs_E, WriteReg_M, RegWrite_M, Tnew_M, WriteReg_W, RegWrite_W);
        FwdRt_E   = fwd_sel(Rt_E, WriteReg_M, RegWrite_M, Tnew_M, WriteReg_W, RegWrite_W);
    end

    // MDU tracker next state: load on start from idle, count down while busy.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (MDUStart_E) begin
                    cnt_n = MDUIsDiv_E ? DIV_LD : MULT_LD;
                    // A zero-cycle op never leaves idle.
                    if (cnt_n != '0) state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_n = cnt - CW'(1);
                if (cnt_n == '0) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // MDU tracker registers; busy is registered from the next count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= (cnt_n != '0);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Free-running count of stalled cycles, wrapping at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_count <= '0;
        else if (stall) stall_count <= stall_count + 32'd1;
    end
`endif

endmodule
